// File: rtl/b03_pkg.sv
// ---------------------------------------------------------------------------
// b03_pkg
//   Shared definitions for the requester-side agent of the four-user b03
//   grant arbiter:
//     - per-user state encoding (IDLE / REQ / USE)
//     - one-hot grant codes as driven by the arbiter on its grant word
//     - is_onehot4()  : legal single-user grant test
//     - user_code()   : maps a user index (0 = user1 .. 3 = user4) to the
//                       grant code that names that user
// ---------------------------------------------------------------------------
package b03_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_USE  = 2'b10
    } user_state_e;

    localparam int NUM_USERS = 4;

    localparam logic [3:0] G_NONE = 4'b0000;
    localparam logic [3:0] G_U1   = 4'b1000;
    localparam logic [3:0] G_U2   = 4'b0100;
    localparam logic [3:0] G_U3   = 4'b0010;
    localparam logic [3:0] G_U4   = 4'b0001;

    // True when exactly one bit of v is set.
    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

    // Grant code that names user index idx (0 = user1 ... 3 = user4).
    function automatic logic [3:0] user_code(input int idx);
        logic [3:0] code;
        case (idx)
            0:       code = G_U1;
            1:       code = G_U2;
            2:       code = G_U3;
            3:       code = G_U4;
            default: code = G_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/b03_client_user.sv
// ---------------------------------------------------------------------------
// b03_client_user
//   One user's slice of the b03 client: pending-job counter, IDLE/REQ/USE
//   state machine, USE countdown, DONE pulse register and sticky overflow.
//
//   Parameters
//     GRANT_CODE : one-hot grant word that names this user
//     HOLD       : cycles spent in USE per job (1..15)
//     CNT_W      : pending counter width; saturates at 2^CNT_W-1
//
//   Ports
//     clk, rst   : clock, asynchronous active-high reset
//     job        : one-cycle job pulse for this user
//     grant      : arbiter grant word as sampled this cycle
//     grant_en   : shared gate; low while any user is in USE or the grant
//                  word is malformed
//     request    : level request to the arbiter (state == REQ)
//     in_use     : this user holds the resource (state == USE)
//     done       : one-cycle completion pulse after the last USE cycle
//     ovf        : sticky, a job arrived while the counter was saturated
// ---------------------------------------------------------------------------
module b03_client_user
    import b03_pkg::*;
#(
    parameter logic [3:0] GRANT_CODE = G_U1,
    parameter int          HOLD       = 4,
    parameter int          CNT_W      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       job,
    input  logic [3:0] grant,
    input  logic       grant_en,
    output logic       request,
    output logic       in_use,
    output logic       done,
    output logic       ovf
);

    localparam logic [3:0]       HOLD_LOAD = 4'(HOLD - 1);
    localparam logic [CNT_W-1:0] PEND_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] PEND_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] PEND_ZERO = '0;

    user_state_e      state_q, state_d;
    logic [CNT_W-1:0] pend_q,  pend_d;
    logic [3:0]       hold_q,  hold_d;
    logic             done_q,  done_d;
    logic             ovf_q,   ovf_d;

    logic             take;

    // A grant is taken only while requesting; stale grants for a user that
    // is not in REQ fall through harmlessly.
    assign take = (state_q == ST_REQ) && grant_en && (grant == GRANT_CODE);

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;

        // Pending counter: an arriving job and a consumed job in the same
        // cycle cancel out, so saturation only matters without a take.
        if (job && !take) begin
            if (pend_q == PEND_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + PEND_ONE;
            end
        end else if (!job && take) begin
            pend_d = pend_q - PEND_ONE;
        end

        case (state_q)
            ST_IDLE: begin
                if (pend_q != PEND_ZERO) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (take) begin
                    state_d = ST_USE;
                    hold_d  = HOLD_LOAD;
                end
            end
            ST_USE: begin
                if (hold_q == 4'd0) begin
                    // The job was already removed from pend_q on entry, so
                    // anything left here is a further queued job.
                    done_d  = 1'b1;
                    state_d = (pend_q != PEND_ZERO) ? ST_REQ : ST_IDLE;
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            hold_q  <= 4'd0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    // Decoded from registered state only: no input reaches these outputs
    // combinationally.
    assign request = (state_q == ST_REQ);
    assign in_use  = (state_q == ST_USE);
    assign done    = done_q;
    assign ovf     = ovf_q;

endmodule

// File: rtl/b03_client.sv
// ---------------------------------------------------------------------------
// b03_client
//   Requester-side agent for the four-user b03 grant arbiter. Converts
//   per-user job pulses into REQUEST1..REQUEST4 levels, accepts the one-hot
//   grant word, holds the resource HOLD cycles per job and pulses DONE.
//
//   Parameters
//     HOLD  : cycles a user occupies the resource per job (1..15)
//     CNT_W : width of each per-user pending counter
//
//   Ports
//     clock, reset       : clock, asynchronous active-high reset
//     JOB[3:0]           : job pulses, bit 3 = user1 ... bit 0 = user4
//     GRANT_I[3:0]       : arbiter grant word (1000 = user1 ... 0001 = user4)
//     REQUEST1..4        : level requests to the arbiter
//     DONE[3:0]          : completion pulses, same bit order as JOB
//     BUSY               : some user is in USE
//     OVF[3:0]           : sticky per-user job-dropped flags
//     GERR               : sticky malformed-grant flag
// ---------------------------------------------------------------------------
module b03_client
    import b03_pkg::*;
#(
    parameter int HOLD  = 4,
    parameter int CNT_W = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] JOB,
    input  logic [3:0] GRANT_I,
    output logic       REQUEST1,
    output logic       REQUEST2,
    output logic       REQUEST3,
    output logic       REQUEST4,
    output logic [3:0] DONE,
    output logic       BUSY,
    output logic [3:0] OVF,
    output logic       GERR
);

    // Index 0 = user1 ... index 3 = user4 in these vectors.
    logic [NUM_USERS-1:0] req_vec;
    logic [NUM_USERS-1:0] use_vec;

    logic use_any;
    logic grant_bad;
    logic grant_en;
    logic gerr_q, gerr_d;

    assign use_any   = |use_vec;
    assign grant_bad = (GRANT_I != G_NONE) && !is_onehot4(GRANT_I);

    // Occupancy is taken from registered state, so a user leaving USE on
    // this edge still blocks grants; the next user enters one cycle later.
    assign grant_en  = !use_any && !grant_bad;

    generate
        for (genvar gi = 0; gi < NUM_USERS; gi++) begin : g_user
            b03_client_user #(
                .GRANT_CODE (user_code(gi)),
                .HOLD       (HOLD),
                .CNT_W      (CNT_W)
            ) u_user (
                .clk      (clock),
                .rst      (reset),
                .job      (JOB[NUM_USERS-1-gi]),
                .grant    (GRANT_I),
                .grant_en (grant_en),
                .request  (req_vec[gi]),
                .in_use   (use_vec[gi]),
                .done     (DONE[NUM_USERS-1-gi]),
                .ovf      (OVF[NUM_USERS-1-gi])
            );
        end
    endgenerate

    always_comb begin
        gerr_d = gerr_q | grant_bad;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gerr_q <= 1'b0;
        end else begin
            gerr_q <= gerr_d;
        end
    end

    assign REQUEST1 = req_vec[0];
    assign REQUEST2 = req_vec[1];
    assign REQUEST3 = req_vec[2];
    assign REQUEST4 = req_vec[3];
    assign BUSY     = use_any;
    assign GERR     = gerr_q;

endmodule
